tl_dma_copy: RTL and testbench



---
 rtl/tl_dma_copy_if.sv | 85 ++++++++
 rtl/tl_dma_copy.sv | 169 ++++++++++++++++
 tb/tb_tl_dma_copy.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_dma_copy_if.sv
// Host-side TileLink bundle (A/B/C/D/E) for the DMA copy engine.
// Latency: none; wires and payload structs only.
// Backpressure: plain valid/ready per channel; master drives A/C/E, slave drives B/D.
interface tl_dma_copy_if #(
  parameter int DataWidth   = 128,
  parameter int AddrWidth   = 38,
  parameter int SourceWidth = 3,
  parameter int SinkWidth   = 4
);
  localparam int MaskWidth = DataWidth / 8;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             param;
    logic [3:0]             size;
    logic [SourceWidth-1:0] source;
    logic [AddrWidth-1:0]   address;
    logic [MaskWidth-1:0]   mask;
    logic [DataWidth-1:0]   data;
    logic                   corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [1:0]             param;
    logic [3:0]             size;
    logic [SourceWidth-1:0] source;
    logic [AddrWidth-1:0]   address;
    logic [MaskWidth-1:0]   mask;
    logic [DataWidth-1:0]   data;
    logic                   corrupt;
  } tl_b_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             param;
    logic [3:0]             size;
    logic [SourceWidth-1:0] source;
    logic [AddrWidth-1:0]   address;
    logic [DataWidth-1:0]   data;
    logic                   corrupt;
  } tl_c_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [1:0]             param;
    logic [3:0]             size;
    logic [SourceWidth-1:0] source;
    logic [SinkWidth-1:0]   sink;
    logic                   denied;
    logic [DataWidth-1:0]   data;
    logic                   corrupt;
  } tl_d_t;

  typedef struct packed {
    logic [SinkWidth-1:0] sink;
  } tl_e_t;

  logic  a_valid, a_ready;
  tl_a_t a;
  logic  b_valid, b_ready;
  tl_b_t b;
  logic  c_valid, c_ready;
  tl_c_t c;
  logic  d_valid, d_ready;
  tl_d_t d;
  logic  e_valid, e_ready;
  tl_e_t e;

  modport master (
    output a_valid, a, input  a_ready,
    input  b_valid, b, output b_ready,
    output c_valid, c, input  c_ready,
    input  d_valid, d, output d_ready,
    output e_valid, e, input  e_ready
  );

  modport slave (
    input  a_valid, a, output a_ready,
    output b_valid, b, input  b_ready,
    input  c_valid, c, output c_ready,
    output d_valid, d, input  d_ready,
    input  e_valid, e, output e_ready
  );
endinterface

// File: rtl/tl_dma_copy.sv
// TileLink-UL bulk copy engine: per beat one Get from src, then one PutFullData to dst.
// Latency: >= 4 cycles per beat plus one FINISH cycle; len 0 or misaligned finishes next cycle.
// Backpressure: A payload held until a_ready; D accepted only in IDLE/RD_RSP/WR_RSP; one txn in flight.
module tl_dma_copy #(
  parameter int DataWidth   = 128,
  parameter int AddrWidth   = 38,
  parameter int SourceWidth = 3,
  parameter int SinkWidth   = 4,
  parameter int LenWidth    = 16,
  parameter int SourceId    = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] src_addr_i,
  input  logic [AddrWidth-1:0] dst_addr_i,
  input  logic [LenWidth-1:0]  len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  tl_dma_copy_if.master        dma_tl
);
  localparam int BeatBytes = DataWidth / 8;
  localparam int SizeVal   = $clog2(BeatBytes);
  localparam logic [AddrWidth-1:0] OffMask  = AddrWidth'(BeatBytes - 1);
  localparam logic [AddrWidth-1:0] BeatStep = AddrWidth'(BeatBytes);
  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpPutFull       = 3'd0;
  localparam logic [2:0] OpAccessAck     = 3'd0;
  localparam logic [2:0] OpAccessAckData = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_REQ, ST_RD_RSP, ST_WR_REQ, ST_WR_RSP, ST_FINISH
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] src_q, src_d, dst_q, dst_d;
  logic [LenWidth-1:0]  rem_q, rem_d;
  logic [DataWidth-1:0] buf_q, buf_d;
  logic                 a_valid_q, a_valid_d, a_put_q, a_put_d, d_ready_q, d_ready_d;
  logic                 busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic                 a_fire, d_fire, misaligned, rd_bad, wr_bad;

  assign a_fire     = a_valid_q && dma_tl.a_ready;
  assign d_fire     = d_ready_q && dma_tl.d_valid;
  assign misaligned = ((src_addr_i | dst_addr_i) & OffMask) != '0;
  assign rd_bad     = (dma_tl.d.opcode != OpAccessAckData) || dma_tl.d.denied || dma_tl.d.corrupt;
  assign wr_bad     = (dma_tl.d.opcode != OpAccessAck) || dma_tl.d.denied;

  // Sequence start/read/write/finish and compute next-cycle registered outputs.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (misaligned) begin
            error_d = 1'b1;
            state_d = ST_FINISH;
          end else if (len_i == '0) begin
            error_d = 1'b0;
            state_d = ST_FINISH;
          end else begin
            src_d   = src_addr_i;
            dst_d   = dst_addr_i;
            rem_d   = len_i;
            error_d = 1'b0;
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: if (a_fire) state_d = ST_RD_RSP;
      ST_RD_RSP: begin
        if (d_fire) begin
          buf_d = dma_tl.d.data;
          if (rd_bad) begin
            error_d = 1'b1;
            state_d = ST_FINISH;
          end else begin
            state_d = ST_WR_REQ;
          end
        end
      end
      ST_WR_REQ: if (a_fire) state_d = ST_WR_RSP;
      ST_WR_RSP: begin
        if (d_fire) begin
          if (wr_bad) begin
            error_d = 1'b1;
            state_d = ST_FINISH;
          end else begin
            src_d   = src_q + BeatStep;
            dst_d   = dst_q + BeatStep;
            rem_d   = rem_q - LenWidth'(1);
            state_d = (rem_q == LenWidth'(1)) ? ST_FINISH : ST_RD_REQ;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    a_valid_d = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
    a_put_d   = (state_d == ST_WR_REQ);
    d_ready_d = (state_d == ST_IDLE) || (state_d == ST_RD_RSP) || (state_d == ST_WR_RSP);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_FINISH);
  end

  // State, datapath and output registers; reset leaves D drainable in IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      buf_q     <= '0;
      a_valid_q <= 1'b0;
      a_put_q   <= 1'b0;
      d_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      buf_q     <= buf_d;
      a_valid_q <= a_valid_d;
      a_put_q   <= a_put_d;
      d_ready_q <= d_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign error_o = error_q;

  // A payload only changes on state transitions, so it is stable while stalled.
  assign dma_tl.a_valid   = a_valid_q;
  assign dma_tl.a.opcode  = a_put_q ? OpPutFull : OpGet;
  assign dma_tl.a.param   = 3'd0;
  assign dma_tl.a.size    = 4'(SizeVal);
  assign dma_tl.a.source  = SourceWidth'(SourceId);
  assign dma_tl.a.address = a_put_q ? dst_q : src_q;
  assign dma_tl.a.mask    = '1;
  assign dma_tl.a.data    = buf_q;
  assign dma_tl.a.corrupt = 1'b0;
  assign dma_tl.d_ready   = d_ready_q;

  // Probes are swallowed; C and E are never used by an uncached host.
  assign dma_tl.b_ready = 1'b1;
  assign dma_tl.c_valid = 1'b0;
  assign dma_tl.c       = '0;
  assign dma_tl.e_valid = 1'b0;
  assign dma_tl.e       = '0;

  logic [SinkWidth-1:0] unused_d_sink;
  logic                 unused_misc;
  assign unused_d_sink = dma_tl.d.sink;
  assign unused_misc   = ^{dma_tl.b_valid, dma_tl.b, dma_tl.c_ready, dma_tl.e_ready,
                           dma_tl.d.param, dma_tl.d.size, dma_tl.d.source};
endmodule

// File: tb/tb_tl_dma_copy.sv
// Bench for tl_dma_copy: table of directed copies, randomized copies with stalls, reset corner.
// Responder model answers A requests from a sparse memory; expectations come from a copy model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_tl_dma_copy;
  localparam int AW = 38;
  localparam int DW = 128;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW-1:0] src_addr_i, dst_addr_i;
  logic [LW-1:0] len_i;
  logic          busy_o, done_o, error_o;

  tl_dma_copy_if #(.DataWidth(DW), .AddrWidth(AW), .SourceWidth(3), .SinkWidth(4)) tl ();

  tl_dma_copy #(
    .DataWidth(DW), .AddrWidth(AW), .SourceWidth(3), .SinkWidth(4), .LenWidth(LW), .SourceId(0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .src_addr_i(src_addr_i),
    .dst_addr_i(dst_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .dma_tl(tl)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_put; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  typedef struct {
    logic [AW-1:0] src; logic [AW-1:0] dst; int len; int fk; int fb;
    int amax; int dmax; bit err; int lat;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // ---------------- responder (memory slave) ----------------
  int amax = 0, dmax = 0, fk = 0, fb = 0;
  bit block_put = 0, inject_ack = 0;
  int n_get, n_put, d_fires = 0, stab_err, fmt_err;
  logic [31:0] seed;
  req_t log_q[$];
  logic [DW-1:0] mem[logic [AW-1:0]];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {seed ^ a[31:0], seed + a[31:0], ~seed, 26'd0, a[37:32]};
  endfunction

  bit a_fire_p = 0, d_fire_p = 0, a_armed = 0, rsp_pend = 0, prev_av = 0, prev_ar = 0;
  bit pend_put;
  int a_wait = 0, d_wait = 0;
  logic [195:0]  prev_a;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data, r_data;
  logic [2:0]    r_op;
  logic          r_den, r_cor;

  initial begin
    tl.a_ready = 0; tl.d_valid = 0; tl.d = '0; tl.b_valid = 0; tl.b = '0;
    tl.c_ready = 1; tl.e_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (a_fire_p) begin
        a_fire_p = 0; a_armed = 0;
        if (pend_put) begin
          n_put++;
          log_q.push_back('{1'b1, pend_addr, pend_data});
          r_op = 3'd0; r_cor = 0; r_data = '0;
          r_den = (fk == 3 && n_put == fb);
          if (!r_den) mem[pend_addr] = pend_data;
        end else begin
          n_get++;
          log_q.push_back('{1'b0, pend_addr, '0});
          r_op = 3'd1;
          r_den = (fk == 1 && n_get == fb);
          r_cor = (fk == 2 && n_get == fb);
          r_data = mem.exists(pend_addr) ? mem[pend_addr] : pat(pend_addr);
        end
        rsp_pend = 1; d_wait = $urandom_range(0, dmax);
      end
      if (d_fire_p) begin d_fire_p = 0; tl.d_valid = 0; d_fires++; end
      if (inject_ack) begin
        inject_ack = 0; r_op = 3'd0; r_den = 0; r_cor = 0; r_data = '0; rsp_pend = 1; d_wait = 0;
      end
      if (rsp_pend && !tl.d_valid) begin
        if (d_wait == 0) begin
          tl.d_valid = 1; tl.d.opcode = r_op; tl.d.denied = r_den; tl.d.corrupt = r_cor;
          tl.d.data = r_data; tl.d.size = 4'd4; tl.d.source = 3'd0; rsp_pend = 0;
        end else d_wait--;
      end
      if (prev_av && !prev_ar && (!tl.a_valid || tl.a != prev_a)) stab_err++;
      if (tl.a_valid && !a_armed) begin a_armed = 1; a_wait = $urandom_range(0, amax); end
      if (!tl.a_valid) tl.a_ready = 0;
      else if (block_put && tl.a.opcode == 3'd0) tl.a_ready = 0;
      else if (a_wait != 0) begin tl.a_ready = 0; a_wait--; end
      else tl.a_ready = 1;
      a_fire_p = tl.a_valid && tl.a_ready;
      if (a_fire_p) begin
        pend_put = (tl.a.opcode == 3'd0); pend_addr = tl.a.address; pend_data = tl.a.data;
        if (tl.a.param != 0 || tl.a.size != 4'd4 || tl.a.source != 0 || tl.a.mask != 16'hFFFF ||
            tl.a.corrupt || !(tl.a.opcode == 3'd4 || tl.a.opcode == 3'd0)) fmt_err++;
      end
      d_fire_p = tl.d_valid && tl.d_ready;
      prev_av = tl.a_valid; prev_ar = tl.a_ready; prev_a = tl.a;
    end
  end

  // ---------------- copy model: expected request stream ----------------
  req_t exp_q[$];
  logic [DW-1:0] mm[logic [AW-1:0]];

  task automatic build_expect(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len,
                              input int f_k, input int f_b);
    logic [AW-1:0] a, w;
    logic [DW-1:0] d;
    exp_q.delete(); mm.delete();
    if (((src | dst) & AW'(15)) == '0) begin
      for (int i = 0; i < len; i++) begin
        a = src + AW'(16 * i);
        w = dst + AW'(16 * i);
        d = mm.exists(a) ? mm[a] : pat(a);
        exp_q.push_back('{1'b0, a, '0});
        if ((f_k == 1 || f_k == 2) && f_b == i + 1) break;
        exp_q.push_back('{1'b1, w, d});
        if (f_k == 3 && f_b == i + 1) break;
        mm[w] = d;
      end
    end
  endtask

  task automatic run_case(input string tag, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input int len, input int f_k, input int f_b, input int a_mx,
                          input int d_mx, input bit exp_err, input int exp_lat);
    int cyc;
    bit seen;
    mem.delete(); seed = $urandom; fk = f_k; fb = f_b; amax = a_mx; dmax = d_mx;
    n_get = 0; n_put = 0; stab_err = 0; fmt_err = 0; log_q.delete();
    build_expect(src, dst, len, f_k, f_b);
    start_i = 1; src_addr_i = src; dst_addr_i = dst; len_i = LW'(len);
    cyc = 0; seen = 0;
    while (!seen && cyc < 600) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) begin
        start_i = 0; src_addr_i = AW'({$urandom, $urandom}); dst_addr_i = AW'({$urandom, $urandom});
        chk($sformatf("%s/busy_after_start", tag), busy_o, 1);
        if (exp_q.size() != 0) chk($sformatf("%s/a_valid_after_start", tag), tl.a_valid, 1);
      end
      if (cyc == 2 && exp_q.size() != 0) begin start_i = 1; len_i = 1; end
      if (cyc == 3) start_i = 0;
      seen = done_o;
    end
    start_i = 0;
    chk($sformatf("%s/done_seen", tag), seen, 1);
    if (exp_lat >= 0) chk($sformatf("%s/done_latency", tag), cyc, exp_lat);
    chk($sformatf("%s/error", tag), error_o, exp_err);
    chk($sformatf("%s/req_count", tag), log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s/req%0d_kind_addr", tag, i), {log_q[i].is_put, log_q[i].addr},
          {exp_q[i].is_put, exp_q[i].addr});
      if (exp_q[i].is_put) chk($sformatf("%s/req%0d_data", tag, i), log_q[i].data, exp_q[i].data);
    end
    chk($sformatf("%s/a_stable", tag), stab_err, 0);
    chk($sformatf("%s/a_format", tag), fmt_err, 0);
    @(posedge clk); #1;
    chk($sformatf("%s/done_one_cycle", tag), done_o, 0);
    chk($sformatf("%s/idle_after", tag), busy_o, 0);
  endtask

  // ---------------- main sequence ----------------
  vec_t tbl[11];

  initial begin
    logic [AW-1:0] s, d;
    int len, fkk, fbb, am, dm, lat, cyc, base;
    bit prev_err, hit, bad_busy, bad_av, bad_done;

    tbl[0]  = '{38'h0_8000_0000, 38'h0_8000_1000, 2, 0, 0, 0, 0, 1'b0, 9};
    tbl[1]  = '{38'h0_8000_0004, 38'h0_8000_1000, 2, 0, 0, 0, 0, 1'b1, 1};
    tbl[2]  = '{38'h0_8000_0000, 38'h0_8000_1000, 0, 0, 0, 0, 0, 1'b0, 1};
    tbl[3]  = '{38'h0_8000_0000, 38'h0_8000_1008, 0, 0, 0, 0, 0, 1'b1, 1};
    tbl[4]  = '{38'h0_8000_2000, 38'h0_8000_3000, 3, 1, 2, 0, 0, 1'b1, 7};
    tbl[5]  = '{38'h0_8000_4000, 38'h0_8000_5000, 1, 0, 0, 0, 0, 1'b0, 5};
    tbl[6]  = '{38'h0_8000_6000, 38'h0_8000_7000, 2, 2, 1, 0, 0, 1'b1, 3};
    tbl[7]  = '{38'h0_8000_8000, 38'h0_8000_9000, 3, 3, 2, 0, 0, 1'b1, 9};
    tbl[8]  = '{38'h3F_FFFF_FFF0, 38'h0_0000_0100, 2, 0, 0, 0, 0, 1'b0, 9};
    tbl[9]  = '{38'h0_8000_0000, 38'h0_8000_1000, 2, 0, 0, 7, 7, 1'b0, -1};
    tbl[10] = '{38'h0_0000_1000, 38'h0_0000_1010, 3, 0, 0, 0, 0, 1'b0, 13};

    rst_i = 1; start_i = 0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    chk("reset/busy", busy_o, 0);
    chk("reset/done", done_o, 0);
    chk("reset/error", error_o, 0);
    chk("reset/a_valid", tl.a_valid, 0);
    chk("reset/d_ready", tl.d_ready, 1);
    chk("reset/b_ready", tl.b_ready, 1);
    chk("reset/c_e_valid", {tl.c_valid, tl.e_valid}, 0);

    prev_err = 0;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("v%0d/error_sticky", i), error_o, prev_err);
      run_case($sformatf("v%0d", i), tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].fk, tbl[i].fb,
               tbl[i].amax, tbl[i].dmax, tbl[i].err, tbl[i].lat);
      prev_err = tbl[i].err;
    end

    for (int k = 0; k < 24; k++) begin
      s = AW'({32'($urandom_range(0, 3)), $urandom}) & ~AW'(15);
      d = (k % 3 == 0) ? s + AW'(16 * $urandom_range(0, 4)) : AW'({32'($urandom_range(0, 3)), $urandom}) & ~AW'(15);
      len = $urandom_range(1, 6);
      fkk = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      fbb = $urandom_range(1, len + 1);
      am = (k % 4 == 0) ? 0 : $urandom_range(0, 7);
      dm = (k % 4 == 0) ? 0 : $urandom_range(0, 7);
      hit = (fkk != 0) && (fbb <= len);
      lat = !hit ? 4 * len + 1 : ((fkk == 3) ? 4 * fbb + 1 : 4 * (fbb - 1) + 3);
      chk($sformatf("r%0d/error_sticky", k), error_o, prev_err);
      run_case($sformatf("r%0d", k), s, d, len, fkk, fbb, am, dm, hit,
               (am == 0 && dm == 0) ? lat : -1);
      prev_err = hit;
    end

    // Reset while a Put is stalled, then a stale AccessAck must drain harmlessly.
    block_put = 1; amax = 0; dmax = 0; fk = 0; mem.delete(); seed = $urandom;
    start_i = 1; src_addr_i = 38'h0_8000_0000; dst_addr_i = 38'h0_8000_1000; len_i = 2;
    @(posedge clk); #1; start_i = 0;
    cyc = 0;
    while (!(tl.a_valid && tl.a.opcode == 3'd0) && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("rst/reached_wr_req", tl.a_valid && tl.a.opcode == 3'd0, 1);
    chk("rst/wr_addr", tl.a.address, 38'h0_8000_1000);
    rst_i = 1;
    @(posedge clk); #1; rst_i = 0;
    chk("rst/a_valid", tl.a_valid, 0);
    chk("rst/busy", busy_o, 0);
    chk("rst/d_ready", tl.d_ready, 1);
    base = d_fires; inject_ack = 1;
    bad_busy = 0; bad_av = 0; bad_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      bad_busy |= busy_o; bad_av |= tl.a_valid; bad_done |= done_o;
    end
    chk("rst/late_ack_accepted", d_fires - base, 1);
    chk("rst/stays_idle", {bad_busy, bad_av, bad_done}, 0);
    chk("rst/d_drained", tl.d_valid, 0);
    block_put = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
